// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester (ic/dc) round-robin arbiter onto one memory port,
//               with separate address/data handshakes and multi-beat reads.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int ADDR_BITS  = 28,
   parameter int DATA_BITS  = 128,
   parameter int READ_BEATS = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   // instruction cache
   input  logic                   ic_mem_req_valid,
   output logic                   ic_mem_req_ready,
   input  logic [ADDR_BITS-1:0]   ic_mem_req_addr,
   input  logic                   ic_mem_req_rw,
   input  logic                   ic_mem_req_data_valid,
   output logic                   ic_mem_req_data_ready,
   input  logic [DATA_BITS-1:0]   ic_mem_req_data_bits,
   input  logic [DATA_BITS/8-1:0] ic_mem_req_data_mask,
   output logic                   ic_mem_resp_valid,
   output logic [DATA_BITS-1:0]   ic_mem_resp_data,
   // data cache
   input  logic                   dc_mem_req_valid,
   output logic                   dc_mem_req_ready,
   input  logic [ADDR_BITS-1:0]   dc_mem_req_addr,
   input  logic                   dc_mem_req_rw,
   input  logic                   dc_mem_req_data_valid,
   output logic                   dc_mem_req_data_ready,
   input  logic [DATA_BITS-1:0]   dc_mem_req_data_bits,
   input  logic [DATA_BITS/8-1:0] dc_mem_req_data_mask,
   output logic                   dc_mem_resp_valid,
   output logic [DATA_BITS-1:0]   dc_mem_resp_data,
   // memory side
   output logic                   mem_req_valid,
   input  logic                   mem_req_ready,
   output logic [ADDR_BITS-1:0]   mem_req_addr,
   output logic                   mem_req_rw,
   output logic                   mem_req_data_valid,
   input  logic                   mem_req_data_ready,
   output logic [DATA_BITS-1:0]   mem_req_data_bits,
   output logic [DATA_BITS/8-1:0] mem_req_data_mask,
   input  logic                   mem_resp_valid,
   input  logic [DATA_BITS-1:0]   mem_resp_data,
   output logic                   stray_resp
);

   localparam int CNT_W = (READ_BEATS > 1) ? $clog2(READ_BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(READ_BEATS - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ADDR   = 2'd1;
   localparam logic [1:0] RBEATS = 2'd2;

   localparam logic OWN_IC = 1'b0;
   localparam logic OWN_DC = 1'b1;

   logic [1:0]       r_state;
   logic             r_owner;
   logic             r_last_grant;
   logic             r_addr_done;
   logic             r_data_done;
   logic [CNT_W-1:0] r_cnt;
   logic             r_stray;

   logic w_in_addr;
   logic w_own_valid;
   logic w_own_rw;
   logic w_own_dv;
   logic w_req_ready;
   logic w_data_ready;
   logic w_addr_fire;
   logic w_data_fire;
   logic w_beat;
   logic w_grant;

   // Request fields are passed straight through from the current owner.
   assign w_own_valid       = (r_owner == OWN_DC) ? dc_mem_req_valid      : ic_mem_req_valid;
   assign w_own_rw          = (r_owner == OWN_DC) ? dc_mem_req_rw         : ic_mem_req_rw;
   assign w_own_dv          = (r_owner == OWN_DC) ? dc_mem_req_data_valid : ic_mem_req_data_valid;
   assign mem_req_addr      = (r_owner == OWN_DC) ? dc_mem_req_addr       : ic_mem_req_addr;
   assign mem_req_data_bits = (r_owner == OWN_DC) ? dc_mem_req_data_bits  : ic_mem_req_data_bits;
   assign mem_req_data_mask = (r_owner == OWN_DC) ? dc_mem_req_data_mask  : ic_mem_req_data_mask;
   assign mem_req_rw        = w_own_rw;

   assign w_in_addr          = (r_state == ADDR);
   assign mem_req_valid      = w_in_addr & w_own_valid & ~r_addr_done;
   assign mem_req_data_valid = w_in_addr & w_own_rw & w_own_dv & ~r_data_done;
   assign w_req_ready        = w_in_addr & mem_req_ready & ~r_addr_done;
   assign w_data_ready       = w_in_addr & w_own_rw & mem_req_data_ready & ~r_data_done;
   assign w_addr_fire        = mem_req_valid & mem_req_ready;
   assign w_data_fire        = mem_req_data_valid & mem_req_data_ready;
   assign w_beat             = (r_state == RBEATS) & mem_resp_valid;

   assign ic_mem_req_ready      = w_req_ready  & (r_owner == OWN_IC);
   assign dc_mem_req_ready      = w_req_ready  & (r_owner == OWN_DC);
   assign ic_mem_req_data_ready = w_data_ready & (r_owner == OWN_IC);
   assign dc_mem_req_data_ready = w_data_ready & (r_owner == OWN_DC);
   assign ic_mem_resp_valid     = w_beat & (r_owner == OWN_IC);
   assign dc_mem_resp_valid     = w_beat & (r_owner == OWN_DC);
   assign ic_mem_resp_data      = mem_resp_data;
   assign dc_mem_resp_data      = mem_resp_data;
   assign stray_resp            = r_stray;

   // On a tie the requester that did not win last time gets the port.
   assign w_grant = (ic_mem_req_valid & dc_mem_req_valid) ? ~r_last_grant : dc_mem_req_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_owner      <= OWN_DC;
         r_last_grant <= OWN_IC;
         r_addr_done  <= 1'b0;
         r_data_done  <= 1'b0;
         r_cnt        <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (ic_mem_req_valid | dc_mem_req_valid) begin
                  r_owner      <= w_grant;
                  r_last_grant <= w_grant;
                  r_state      <= ADDR;
               end
            end
            ADDR: begin
               if (!w_own_rw) begin
                  if (w_addr_fire) begin
                     r_state <= RBEATS;
                     r_cnt   <= '0;
                  end
               end else if ((r_addr_done | w_addr_fire) & (r_data_done | w_data_fire)) begin
                  r_state     <= IDLE;
                  r_addr_done <= 1'b0;
                  r_data_done <= 1'b0;
               end else begin
                  if (w_addr_fire) r_addr_done <= 1'b1;
                  if (w_data_fire) r_data_done <= 1'b1;
               end
            end
            RBEATS: begin
               if (mem_resp_valid) begin
                  if (r_cnt == LAST_BEAT) begin
                     r_state <= IDLE;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                   r_stray <= 1'b0;
      else if (mem_resp_valid && r_state != RBEATS) r_stray <= 1'b1;
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: directed vector table,
//               corner sequences and a randomized run against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
   localparam int AB = 28;
   localparam int DB = 128;
   localparam int MB = DB / 8;
   localparam int RB = 4;

   localparam logic [AB-1:0] IC_ADDR = 28'h0000123;
   localparam logic [AB-1:0] DC_ADDR = 28'h0000456;
   localparam logic [DB-1:0] DC_BITS = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
   localparam logic [MB-1:0] DC_MASK = 16'hA5C3;

   logic          clk = 1'b0;
   logic          reset;
   logic          ic_mem_req_valid, ic_mem_req_ready, ic_mem_req_rw;
   logic [AB-1:0] ic_mem_req_addr;
   logic          ic_mem_req_data_valid, ic_mem_req_data_ready;
   logic [DB-1:0] ic_mem_req_data_bits;
   logic [MB-1:0] ic_mem_req_data_mask;
   logic          ic_mem_resp_valid;
   logic [DB-1:0] ic_mem_resp_data;
   logic          dc_mem_req_valid, dc_mem_req_ready, dc_mem_req_rw;
   logic [AB-1:0] dc_mem_req_addr;
   logic          dc_mem_req_data_valid, dc_mem_req_data_ready;
   logic [DB-1:0] dc_mem_req_data_bits;
   logic [MB-1:0] dc_mem_req_data_mask;
   logic          dc_mem_resp_valid;
   logic [DB-1:0] dc_mem_resp_data;
   logic          mem_req_valid, mem_req_ready, mem_req_rw;
   logic [AB-1:0] mem_req_addr;
   logic          mem_req_data_valid, mem_req_data_ready;
   logic [DB-1:0] mem_req_data_bits;
   logic [MB-1:0] mem_req_data_mask;
   logic          mem_resp_valid;
   logic [DB-1:0] mem_resp_data;
   logic          stray_resp;

   mem_arbiter #(.ADDR_BITS(AB), .DATA_BITS(DB), .READ_BEATS(RB)) dut (
      .clk(clk), .reset(reset),
      .ic_mem_req_valid(ic_mem_req_valid), .ic_mem_req_ready(ic_mem_req_ready),
      .ic_mem_req_addr(ic_mem_req_addr), .ic_mem_req_rw(ic_mem_req_rw),
      .ic_mem_req_data_valid(ic_mem_req_data_valid), .ic_mem_req_data_ready(ic_mem_req_data_ready),
      .ic_mem_req_data_bits(ic_mem_req_data_bits), .ic_mem_req_data_mask(ic_mem_req_data_mask),
      .ic_mem_resp_valid(ic_mem_resp_valid), .ic_mem_resp_data(ic_mem_resp_data),
      .dc_mem_req_valid(dc_mem_req_valid), .dc_mem_req_ready(dc_mem_req_ready),
      .dc_mem_req_addr(dc_mem_req_addr), .dc_mem_req_rw(dc_mem_req_rw),
      .dc_mem_req_data_valid(dc_mem_req_data_valid), .dc_mem_req_data_ready(dc_mem_req_data_ready),
      .dc_mem_req_data_bits(dc_mem_req_data_bits), .dc_mem_req_data_mask(dc_mem_req_data_mask),
      .dc_mem_resp_valid(dc_mem_resp_valid), .dc_mem_resp_data(dc_mem_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
      .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
      .mem_req_data_bits(mem_req_data_bits), .mem_req_data_mask(mem_req_data_mask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
      .stray_resp(stray_resp)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // in : ic_v ic_rw ic_dv dc_v dc_rw dc_dv mem_rdy mem_drdy mem_resp
   // ex : mvalid mdvalid ic_rdy dc_rdy ic_drdy dc_drdy ic_resp dc_resp stray
   typedef struct {
      logic [8:0] in;
      logic [8:0] ex;
   } vec_t;
   vec_t tbl[16];

   task automatic apply(input logic [8:0] v);
      ic_mem_req_valid      = v[8];
      ic_mem_req_rw         = v[7];
      ic_mem_req_data_valid = v[6];
      dc_mem_req_valid      = v[5];
      dc_mem_req_rw         = v[4];
      dc_mem_req_data_valid = v[3];
      mem_req_ready         = v[2];
      mem_req_data_ready    = v[1];
      mem_resp_valid        = v[0];
      ic_mem_req_addr       = IC_ADDR;
      dc_mem_req_addr       = DC_ADDR;
      ic_mem_req_data_bits  = '0;
      ic_mem_req_data_mask  = '0;
      dc_mem_req_data_bits  = DC_BITS;
      dc_mem_req_data_mask  = DC_MASK;
   endtask

   function automatic logic [8:0] outs();
      return {mem_req_valid, mem_req_data_valid, ic_mem_req_ready, dc_mem_req_ready,
              ic_mem_req_data_ready, dc_mem_req_data_ready, ic_mem_resp_valid,
              dc_mem_resp_valid, stray_resp};
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      apply(9'b0);
      mem_resp_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // ---------------- reference model for the randomized run ----------------
   typedef struct {
      logic          active, v, rw, dv, a_done, d_done;
      logic [AB-1:0] a;
      logic [DB-1:0] d;
      logic [MB-1:0] m;
   } rq_t;
   rq_t  rq[2];
   logic f_a[2];
   logic f_d[2];
   logic m_busy, m_reading, m_who, m_last, m_addr_ok, m_data_ok, m_stray;
   int   m_beats_left;

   task automatic drive_rq();
      ic_mem_req_valid      = rq[0].v;
      ic_mem_req_rw         = rq[0].rw;
      ic_mem_req_data_valid = rq[0].dv;
      ic_mem_req_addr       = rq[0].a;
      ic_mem_req_data_bits  = rq[0].d;
      ic_mem_req_data_mask  = rq[0].m;
      dc_mem_req_valid      = rq[1].v;
      dc_mem_req_rw         = rq[1].rw;
      dc_mem_req_data_valid = rq[1].dv;
      dc_mem_req_addr       = rq[1].a;
      dc_mem_req_data_bits  = rq[1].d;
      dc_mem_req_data_mask  = rq[1].m;
   endtask

   task automatic upd_requesters();
      for (int i = 0; i < 2; i++) begin
         if (f_a[i]) begin rq[i].v  = 1'b0; rq[i].a_done = 1'b1; end
         if (f_d[i]) begin rq[i].dv = 1'b0; rq[i].d_done = 1'b1; end
         if (rq[i].active && rq[i].a_done && (!rq[i].rw || rq[i].d_done)) rq[i].active = 1'b0;
         if (rq[i].active && rq[i].rw && !rq[i].d_done && !rq[i].dv && ($urandom % 2 == 0))
            rq[i].dv = 1'b1;
         if (!rq[i].active && ($urandom % 3 == 0)) begin
            rq[i].active = 1'b1;
            rq[i].v      = 1'b1;
            rq[i].a      = AB'($urandom);
            rq[i].rw     = 1'($urandom % 2);
            rq[i].dv     = rq[i].rw & 1'($urandom % 2);
            rq[i].d      = {$urandom, $urandom, $urandom, $urandom};
            rq[i].m      = MB'($urandom);
            rq[i].a_done = 1'b0;
            rq[i].d_done = 1'b0;
         end
      end
   endtask

   task automatic rand_mem();
      mem_req_ready      = 1'($urandom % 2);
      mem_req_data_ready = 1'($urandom % 2);
      mem_resp_valid     = m_reading ? ($urandom % 3 != 0) : ($urandom % 200 == 0);
      mem_resp_data      = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic model_check_step();
      rq_t  ow;
      logic rp, e_mv, e_rdy, e_dv, e_drdy, e_resp, afire, dfire;
      ow     = rq[m_who];
      rp     = m_busy && !m_reading;
      e_mv   = rp && ow.v && !m_addr_ok;
      e_rdy  = rp && mem_req_ready && !m_addr_ok;
      e_dv   = rp && ow.rw && ow.dv && !m_data_ok;
      e_drdy = rp && ow.rw && mem_req_data_ready && !m_data_ok;
      e_resp = m_reading && mem_resp_valid;
      chk("rnd_mem_req_valid", mem_req_valid, e_mv);
      chk("rnd_mem_data_valid", mem_req_data_valid, e_dv);
      chk("rnd_ic_ready", ic_mem_req_ready, e_rdy && !m_who);
      chk("rnd_dc_ready", dc_mem_req_ready, e_rdy && m_who);
      chk("rnd_ic_data_ready", ic_mem_req_data_ready, e_drdy && !m_who);
      chk("rnd_dc_data_ready", dc_mem_req_data_ready, e_drdy && m_who);
      chk("rnd_ic_resp", ic_mem_resp_valid, e_resp && !m_who);
      chk("rnd_dc_resp", dc_mem_resp_valid, e_resp && m_who);
      chk("rnd_stray", stray_resp, m_stray);
      if (e_mv) begin
         chk("rnd_addr", mem_req_addr, ow.a);
         chk("rnd_rw", mem_req_rw, ow.rw);
      end
      if (e_dv) begin
         chk("rnd_bits", mem_req_data_bits, ow.d);
         chk("rnd_mask", mem_req_data_mask, ow.m);
      end
      if (e_resp) chk("rnd_resp_data", m_who ? dc_mem_resp_data : ic_mem_resp_data, mem_resp_data);

      afire = e_mv && mem_req_ready;
      dfire = e_dv && mem_req_data_ready;
      f_a[0] = afire && !m_who;
      f_a[1] = afire && m_who;
      f_d[0] = dfire && !m_who;
      f_d[1] = dfire && m_who;
      if (mem_resp_valid && !m_reading) m_stray = 1'b1;
      if (!m_busy) begin
         if (rq[0].v || rq[1].v) begin
            m_who     = (rq[0].v && rq[1].v) ? !m_last : rq[1].v;
            m_last    = m_who;
            m_busy    = 1'b1;
            m_addr_ok = 1'b0;
            m_data_ok = 1'b0;
         end
      end else if (!m_reading) begin
         if (!ow.rw) begin
            if (afire) begin
               m_reading    = 1'b1;
               m_beats_left = RB;
            end
         end else begin
            m_addr_ok = m_addr_ok | afire;
            m_data_ok = m_data_ok | dfire;
            if (m_addr_ok && m_data_ok) m_busy = 1'b0;
         end
      end else if (mem_resp_valid) begin
         m_beats_left--;
         if (m_beats_left == 0) begin
            m_reading = 1'b0;
            m_busy    = 1'b0;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   logic [DB-1:0] bdata;
   logic          seen, drop, cur;
   int            order[4];
   int            ng, beats, cnt;

   initial begin
      // ic read, dc write with late address, stray beat, beat during ADDR
      tbl[0]  = '{9'b100_000_100, 9'b000_000_000};
      tbl[1]  = '{9'b100_000_100, 9'b101_000_000};
      tbl[2]  = '{9'b000_000_101, 9'b000_000_100};
      tbl[3]  = '{9'b000_000_101, 9'b000_000_100};
      tbl[4]  = '{9'b000_000_101, 9'b000_000_100};
      tbl[5]  = '{9'b000_000_101, 9'b000_000_100};
      tbl[6]  = '{9'b000_000_000, 9'b000_000_000};
      tbl[7]  = '{9'b000_111_010, 9'b000_000_000};
      tbl[8]  = '{9'b000_111_010, 9'b110_001_000};
      tbl[9]  = '{9'b000_111_010, 9'b100_000_000};
      tbl[10] = '{9'b000_111_110, 9'b100_100_000};
      tbl[11] = '{9'b000_000_000, 9'b000_000_000};
      tbl[12] = '{9'b000_000_001, 9'b000_000_000};
      tbl[13] = '{9'b000_000_000, 9'b000_000_001};
      tbl[14] = '{9'b100_000_000, 9'b000_000_001};
      tbl[15] = '{9'b100_000_001, 9'b100_000_001};

      // reset holds every output low even with all inputs active
      reset = 1'b1;
      apply(9'b100_100_111);
      mem_resp_data = '1;
      #12;
      chk("reset_outputs", outs(), 9'b0);
      apply(9'b0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         apply(tbl[i].in);
         bdata = {4{32'(i) * 32'h0101_0101}};
         mem_resp_data = bdata;
         @(negedge clk);
         chk($sformatf("vec_row%0d", i), outs(), tbl[i].ex);
         if (tbl[i].ex[8]) begin
            chk($sformatf("vec_addr%0d", i), mem_req_addr, tbl[i].in[8] ? IC_ADDR : DC_ADDR);
            chk($sformatf("vec_rw%0d", i), mem_req_rw, tbl[i].in[8] ? tbl[i].in[7] : tbl[i].in[4]);
         end
         if (tbl[i].ex[7]) begin
            chk("vec_bits", mem_req_data_bits, DC_BITS);
            chk("vec_mask", mem_req_data_mask, DC_MASK);
         end
         if (tbl[i].ex[2]) chk($sformatf("vec_ic_data%0d", i), ic_mem_resp_data, bdata);
      end

      // continuous reads from both: alternate grants starting with dc
      do_reset();
      @(posedge clk); #1;
      apply(9'b100_100_101);
      ng = 0; beats = 0; cur = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (ic_mem_resp_valid || dc_mem_resp_valid) begin
            beats++;
            chk("alt_resp_owner", dc_mem_resp_valid, cur);
            chk("alt_resp_single", ic_mem_resp_valid & dc_mem_resp_valid, 1'b0);
         end
         if (ic_mem_req_ready || dc_mem_req_ready) begin
            chk("alt_no_overlap", ic_mem_req_ready & dc_mem_req_ready, 1'b0);
            if (ng > 0 && ng <= 4) chk("alt_beats_per_read", beats, RB);
            if (ng < 4) order[ng] = int'(dc_mem_req_ready);
            ng++;
            cur   = dc_mem_req_ready;
            beats = 0;
         end
      end
      chk("alt_grant_count", ng >= 4, 1'b1);
      chk("alt_order0", order[0], 1);
      chk("alt_order1", order[1], 0);
      chk("alt_order2", order[2], 1);
      chk("alt_order3", order[3], 0);

      // reset in the middle of an ic read, then a clean dc read
      do_reset();
      @(posedge clk); #1;
      apply(9'b100_000_100);
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
         @(negedge clk);
         if (ic_mem_req_ready) seen = 1'b1;
      end
      chk("abort_grant_seen", seen, 1'b1);
      @(posedge clk); #1;
      apply(9'b000_000_101);
      @(negedge clk);
      chk("abort_beat0", ic_mem_resp_valid, 1'b1);
      @(negedge clk);
      chk("abort_beat1", ic_mem_resp_valid, 1'b1);
      @(posedge clk); #1;
      apply(9'b100_100_111);
      #1 reset = 1'b1;
      #1 chk("abort_outputs_in_reset", outs(), 9'b0);
      @(negedge clk);
      apply(9'b000_000_001);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_stray_no_resp", {ic_mem_resp_valid, dc_mem_resp_valid}, 2'b00);
      @(negedge clk);
      chk("abort_stray_no_resp2", {ic_mem_resp_valid, dc_mem_resp_valid}, 2'b00);
      @(posedge clk); #1;
      apply(9'b000_000_000);
      @(negedge clk);
      chk("abort_stray_flag", stray_resp, 1'b1);
      @(posedge clk); #1;
      apply(9'b000_100_101);
      cnt = 0; drop = 1'b0;
      repeat (14) begin
         @(negedge clk);
         if (dc_mem_resp_valid) cnt++;
         if (ic_mem_resp_valid) chk("abort_ic_quiet", ic_mem_resp_valid, 1'b0);
         if (dc_mem_req_ready) drop = 1'b1;
         @(posedge clk); #1;
         if (drop) dc_mem_req_valid = 1'b0;
      end
      chk("abort_dc_beats", cnt, RB);
      chk("abort_stray_sticky", stray_resp, 1'b1);

      // randomized run against the reference model
      do_reset();
      for (int i = 0; i < 2; i++) begin
         rq[i] = '{default: '0};
         f_a[i] = 1'b0;
         f_d[i] = 1'b0;
      end
      m_busy = 1'b0; m_reading = 1'b0; m_who = 1'b1; m_last = 1'b0;
      m_addr_ok = 1'b0; m_data_ok = 1'b0; m_stray = 1'b0; m_beats_left = 0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         upd_requesters();
         rand_mem();
         drive_rq();
         @(negedge clk);
         model_check_step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
